// File: rtl/acc_requant_pkg.sv
// Shared widths, saturation bounds and pipeline stage payload for the dyadic requantizer.
package acc_requant_pkg;

    localparam int unsigned D_W_ACC_DEF = 32;
    localparam int unsigned M_W_DEF     = 32;
    localparam int unsigned S_W_DEF     = 6;
    localparam int unsigned D_W_OUT_DEF = 8;
    localparam int unsigned CNT_W_DEF   = 16;

    // Signed product of a signed accumulator and a zero-extended unsigned multiplier
    function automatic int unsigned p_w(input int unsigned acc_w, input int unsigned mult_w);
        return acc_w + mult_w + 1;
    endfunction

    localparam int unsigned P_W_DEF = p_w(D_W_ACC_DEF, M_W_DEF);

    function automatic longint sat_max(input int unsigned out_w);
        return (longint'(1) <<< (out_w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int unsigned out_w);
        return -(longint'(1) <<< (out_w - 1));
    endfunction

    typedef struct packed {
        logic                       valid;
        logic signed [P_W_DEF-1:0]  product;
        logic        [S_W_DEF-1:0]  shift;
    } stage_t;

endpackage

// File: rtl/acc_requant_if.sv
// Input accumulator/config handshake and output activation handshake of acc_requant.
interface acc_requant_if #(
    parameter int unsigned D_W_ACC = 32,
    parameter int unsigned M_W     = 32,
    parameter int unsigned S_W     = 6,
    parameter int unsigned D_W_OUT = 8
) ();

    logic                      in_valid;
    logic                      in_ready;
    logic signed [D_W_ACC-1:0] in_data;
    logic        [M_W-1:0]     cfg_mult;
    logic        [S_W-1:0]     cfg_shift;
    logic                      out_valid;
    logic                      out_ready;
    logic        [D_W_OUT-1:0] out_data;

    modport master (
        output in_valid, in_data, cfg_mult, cfg_shift, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, cfg_mult, cfg_shift, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/acc_requant_round_shift_sat.sv
// Combinational round-half-up arithmetic shift and signed saturation used between
// the requantizer pipeline registers.
module round_shift_sat
    import acc_requant_pkg::*;
#(
    parameter int unsigned P_W     = P_W_DEF,
    parameter int unsigned S_W     = S_W_DEF,
    parameter int unsigned D_W_OUT = D_W_OUT_DEF
) (
    input  logic signed [P_W-1:0]     product,
    input  logic        [S_W-1:0]     shift,
    output logic signed [P_W-1:0]     rounded_c,
    input  logic signed [P_W-1:0]     value,
    output logic        [D_W_OUT-1:0] result_c,
    output logic                      sat_c
);

    localparam logic signed [P_W-1:0] MAX_V = P_W'(sat_max(D_W_OUT));
    localparam logic signed [P_W-1:0] MIN_V = P_W'(sat_min(D_W_OUT));

    logic signed [P_W-1:0] rnd;

    // P_W leaves one spare bit above the largest product, so adding half an LSB cannot wrap
    always_comb begin
        rnd = '0;
        if (shift != '0) begin
            rnd = P_W'(1) <<< (shift - S_W'(1));
        end
        rounded_c = (product + rnd) >>> shift;
    end

    always_comb begin
        result_c = value[D_W_OUT-1:0];
        sat_c    = 1'b0;
        if (value > MAX_V) begin
            result_c = MAX_V[D_W_OUT-1:0];
            sat_c    = 1'b1;
        end else if (value < MIN_V) begin
            result_c = MIN_V[D_W_OUT-1:0];
            sat_c    = 1'b1;
        end
    end

endmodule

// File: rtl/acc_requant.sv
// Three-stage stallable requantizer: multiply, round/shift, saturate, plus a sticky
// saturation event counter.
module acc_requant
    import acc_requant_pkg::*;
#(
    parameter int unsigned D_W_ACC = D_W_ACC_DEF,
    parameter int unsigned M_W     = M_W_DEF,
    parameter int unsigned S_W     = S_W_DEF,
    parameter int unsigned D_W_OUT = D_W_OUT_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    acc_requant_if.slave      bus,
    input  logic              clr_count,
    output logic [CNT_W-1:0]  sat_count
);

    localparam int unsigned P_W = p_w(D_W_ACC, M_W);

    stage_t                 s1_q;
    logic                   s2_valid_q;
    logic signed [P_W-1:0]  s2_value_q;

    logic                   adv;
    logic signed [P_W-1:0]  prod_c;
    logic signed [P_W-1:0]  rounded_c;
    logic [D_W_OUT-1:0]     result_c;
    logic                   sat_c;

    // A single advance enable freezes the whole pipe whenever the held output is not taken
    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    assign prod_c = P_W'($signed(bus.in_data)) * $signed(P_W'(bus.cfg_mult));

    round_shift_sat #(
        .P_W     (P_W),
        .S_W     (S_W),
        .D_W_OUT (D_W_OUT)
    ) u_round_shift_sat (
        .product   (s1_q.product),
        .shift     (s1_q.shift),
        .rounded_c (rounded_c),
        .value     (s2_value_q),
        .result_c  (result_c),
        .sat_c     (sat_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q          <= '0;
            s2_valid_q    <= 1'b0;
            s2_value_q    <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
        end else if (adv) begin
            s1_q.valid    <= bus.in_valid;
            s1_q.product  <= prod_c;
            s1_q.shift    <= bus.cfg_shift;
            s2_valid_q    <= s1_q.valid;
            s2_value_q    <= rounded_c;
            bus.out_valid <= s2_valid_q;
            bus.out_data  <= result_c;
        end
    end

    // Clear wins over a same-cycle clamp; count sticks at all-ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_count <= '0;
        end else if (clr_count) begin
            sat_count <= '0;
        end else if (adv && s2_valid_q && sat_c && (sat_count != {CNT_W{1'b1}})) begin
            sat_count <= sat_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_acc_requant.sv
// Directed-vector bench for acc_requant: latency, rounding, saturation counter,
// backpressure, per-word config capture and mid-stream reset.
module tb_acc_requant;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_count;
    logic [15:0] sat_count;
    int          vectors = 0;
    int          errors  = 0;

    acc_requant_if bus ();

    acc_requant dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .clr_count (clr_count),
        .sat_count (sat_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) step();
    endtask

    // Offer one word, then expect its result exactly three edges after acceptance
    task automatic send_one(input string name, input logic signed [31:0] d,
                            input logic [31:0] m, input logic [5:0] s,
                            input logic signed [7:0] expv);
        int lat;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.cfg_mult  = m;
        bus.cfg_shift = s;
        bus.out_ready = 1'b1;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready: got %b want 1", name, bus.in_ready);
        end
        step();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 10) begin
            step();
            lat++;
        end
        vectors++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL %s latency: got %0d want 3", name, lat);
        end
        vectors++;
        if (bus.out_data !== expv) begin
            errors++;
            $display("FAIL %s out_data: got %0d want %0d", name, $signed(bus.out_data), expv);
        end
    endtask

    task automatic test_reset();
        vectors++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", bus.out_valid); end
        vectors++;
        if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset out_data: got %h want 00", bus.out_data); end
        vectors++;
        if (sat_count !== 16'd0) begin errors++; $display("FAIL reset sat_count: got %0d want 0", sat_count); end
        vectors++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_basic();
        drain();
        send_one("basic_200", 32'sd200, 32'h4000_0000, 6'd31, 8'sd100);
    endtask

    task automatic test_rounding();
        drain();
        send_one("round_p3", 32'sd3, 32'd1, 6'd1, 8'sd2);
        send_one("round_m3", -32'sd3, 32'd1, 6'd1, -8'sd1);
        send_one("round_m4", -32'sd4, 32'd1, 6'd1, -8'sd2);
        send_one("shift0_5", 32'sd5, 32'd1, 6'd0, 8'sd5);
    endtask

    task automatic test_saturation();
        drain();
        send_one("sat_hi", 32'sd1000, 32'd1, 6'd0, 8'sd127);
        send_one("sat_lo", -32'sd1000, 32'd1, 6'd0, -8'sd128);
        vectors++;
        if (sat_count !== 16'd2) begin errors++; $display("FAIL sat_count_two: got %0d want 2", sat_count); end
        bus.in_valid = 1'b1;
        bus.in_data  = 32'sd1000;
        step();
        bus.in_valid = 1'b0;
        step();
        clr_count = 1'b1;
        step();
        clr_count = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'sd127) begin
            errors++;
            $display("FAIL sat_third: got valid %b data %0d want 1 127", bus.out_valid, $signed(bus.out_data));
        end
        vectors++;
        if (sat_count !== 16'd0) begin errors++; $display("FAIL clr_priority: got %0d want 0", sat_count); end
        step();
        vectors++;
        if (sat_count !== 16'd0) begin errors++; $display("FAIL clr_hold: got %0d want 0", sat_count); end
    endtask

    task automatic test_backpressure();
        logic [7:0] got[$];
        logic [7:0] held;
        logic       was_stalled;
        logic       accept;
        logic       take;
        logic       exp_ir;
        int         c;
        int         nxt;
        drain();
        bus.cfg_mult  = 32'd1;
        bus.cfg_shift = 6'd0;
        c = 0;
        nxt = 1;
        was_stalled = 1'b0;
        held = '0;
        while (got.size() < 8 && c < 40) begin
            bus.out_ready = !(c >= 4 && c <= 9);
            bus.in_valid  = (nxt <= 8);
            bus.in_data   = 32'(nxt);
            #1;
            exp_ir = !(c >= 4 && c <= 9);
            vectors++;
            if (bus.in_ready !== exp_ir) begin
                errors++;
                $display("FAIL bp_in_ready c=%0d: got %b want %b", c, bus.in_ready, exp_ir);
            end
            if (was_stalled) begin
                vectors++;
                if (bus.out_data !== held) begin
                    errors++;
                    $display("FAIL bp_stable c=%0d: got %0d want %0d", c, bus.out_data, held);
                end
            end
            accept      = bus.in_valid && bus.in_ready;
            take        = bus.out_valid && bus.out_ready;
            was_stalled = bus.out_valid && !bus.out_ready;
            held        = bus.out_data;
            if (take) got.push_back(bus.out_data);
            step();
            if (accept) nxt++;
            c++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        vectors++;
        if (got.size() != 8) begin errors++; $display("FAIL bp_count: got %0d want 8", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            vectors++;
            if (got[i] !== 8'(i + 1)) begin
                errors++;
                $display("FAIL bp_order[%0d]: got %0d want %0d", i, got[i], i + 1);
            end
        end
    endtask

    task automatic test_config_change();
        logic [7:0] got[$];
        int         when_seen[$];
        int         c;
        drain();
        bus.cfg_shift = 6'd0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'sd10;
        bus.cfg_mult  = 32'd1;
        step();
        bus.cfg_mult  = 32'd2;
        step();
        bus.in_valid  = 1'b0;
        bus.cfg_mult  = 32'd1;
        c = 0;
        while (got.size() < 2 && c < 10) begin
            if (bus.out_valid === 1'b1) begin
                got.push_back(bus.out_data);
                when_seen.push_back(c);
            end
            step();
            c++;
        end
        vectors++;
        if (got.size() != 2) begin
            errors++;
            $display("FAIL cfg_count: got %0d want 2", got.size());
        end else begin
            vectors++;
            if (got[0] !== 8'd10) begin errors++; $display("FAIL cfg_first: got %0d want 10", got[0]); end
            vectors++;
            if (got[1] !== 8'd20) begin errors++; $display("FAIL cfg_second: got %0d want 20", got[1]); end
            vectors++;
            if (when_seen[1] - when_seen[0] !== 1) begin
                errors++;
                $display("FAIL cfg_throughput: got gap %0d want 1", when_seen[1] - when_seen[0]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        drain();
        send_one("pre_rst_sat", 32'sd1000, 32'd1, 6'd0, 8'sd127);
        vectors++;
        if (sat_count !== 16'd1) begin errors++; $display("FAIL pre_rst_count: got %0d want 1", sat_count); end
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_data = 32'(7 + i);
            step();
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
        vectors++;
        if (sat_count !== 16'd0) begin errors++; $display("FAIL rst_sat_count: got %0d want 0", sat_count); end
        vectors++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        step();
        send_one("post_rst", 32'sd42, 32'd1, 6'd0, 8'sd42);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst           = 1'b0;
        clr_count     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.cfg_mult  = '0;
        bus.cfg_shift = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        step();
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_config_change();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/acc_requant.md
# acc_requant

Downstream stage of the MAC array. Takes signed `D_W_ACC` accumulator results, applies the I-BERT dyadic requantization `out = sat(round((acc * mult) >> shift))`, and emits signed `D_W_OUT` activations for the next layer. It is a 3-stage, fully stallable valid/ready pipeline, and it keeps a saturation event counter for calibration debug.

## Interface
Parameters:
- `D_W_ACC`, 32, accumulator input width (signed).
- `M_W`, 32, multiplier width (unsigned).
- `S_W`, 6, shift amount width.
- `D_W_OUT`, 8, output width (signed).
- `CNT_W`, 16, saturation counter width.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset.
- `in_valid` in 1: accumulator word offered.
- `in_ready` out 1: stage 1 can accept.
- `in_data` in `D_W_ACC`: signed accumulator.
- `cfg_mult` in `M_W`: unsigned dyadic multiplier, sampled with each accepted word.
- `cfg_shift` in `S_W`: right shift (0..2^S_W−1), sampled with each accepted word.
- `out_valid` out 1: result held.
- `out_ready` in 1: consumer accepts.
- `out_data` out `D_W_OUT`: signed saturated result.
- `clr_count` in 1: synchronous clear of `sat_count`.
- `sat_count` out `CNT_W`: number of saturated results, sticky at all-ones.

## Operation
- Product width `P_W = D_W_ACC + M_W + 1`, signed; `cfg_mult` is zero-extended.
- S1 (multiply): `p1 = in_data * cfg_mult`. Store `p1`, `shift` and a valid bit.
- S2 (round/shift): if `shift == 0`, `r2 = p1`. Otherwise `r2 = (p1 + 2^(shift−1)) >>> shift`. This is round-half-toward-+inf. Worked values: 1.5 gives 2, −1.5 gives −1. The addition must not overflow `P_W`.
- S3 (saturate):
  - `r2 > 2^(D_W_OUT−1)−1` gives the max value (127).
  - `r2 < −2^(D_W_OUT−1)` gives the min value (−128).
  - Otherwise `r2` is truncated.
  - The output register loads `out_data`/`out_valid`. A load that clamps raises the saturation flag for that word.
- Global advance: `adv = !out_valid || out_ready`.
  - `in_ready = adv`.
  - All stage registers, valid bits included, load only when `adv` is true.
  - Bubbles are not collapsed.
- Config is captured per word at S1, so changing `cfg_*` mid-stream affects only later words.
- `sat_count` increments by 1 when S3 loads a valid clamped word. It holds at all-ones.
  - `clr_count` has priority: clear and increment in the same cycle gives 0.
  - `clr_count` has no effect on the datapath.

## Timing
- Reset (async assert, sync release): all valid bits 0, `out_valid = 0`, `out_data = 0`, `sat_count = 0`, `in_ready = 1`.
- Latency: a word accepted in cycle N appears with `out_valid = 1` in cycle N+3 when `adv` stays high.
- Throughput: 1 word/cycle with `out_ready` held high.
- Stall: `out_valid && !out_ready` freezes every stage. `in_ready` drops combinationally in the same cycle. No word is lost or duplicated, and `out_data` is stable while stalled.
- Reset mid-stream: in-flight words are discarded and no partial output appears.
- Simultaneous `in_valid` and a stall: the input is not taken. The source must hold its data.

## Structure
- Package `acc_requant_pkg`: `P_W` derivation function, the saturation min/max constants as functions of `D_W_OUT`, and a `stage_t` struct (valid, product, shift).
- One sub-module, `round_shift_sat`: the combinational S2/S3 arithmetic, unit-testable on its own. Pipeline registers and the counter stay in the top module.

## Test plan
- `in=200`, `mult=2^30`, `shift=31`, `out_ready=1` -> `out_data=100` exactly 3 cycles after acceptance.
- Rounding, with `mult=1`, `shift=1`:
  - `in=3` -> 2.
  - `in=−3` -> −1.
  - `in=−4` -> −2.
  - `shift=0` with `in=5`, `mult=1` -> 5, and no rounding constant is added.
- Saturation, with `mult=1`, `shift=0`: `in=1000` -> 127, then `in=−1000` -> −128.
  - `sat_count` reads 2.
  - `clr_count` pulsed on the cycle of a third clamp -> `sat_count=0`.
- Backpressure: stream 1..8, `out_ready` low for cycles 4–9 -> `in_ready` low exactly while stalled, and outputs arrive in order 1..8 with no gaps lost or repeated.
- Config change: `mult` switches from 1 to 2 between consecutive words 10 and 10 -> outputs 10, then 20.
- Reset asserted while 3 words are in flight -> `out_valid=0` and `sat_count=0` immediately. The first output after release corresponds to the first post-reset input.
